// File: rtl/cnt_bank.sv
// cnt_bank: N-channel event counter bank, coherent snapshot, scanning read mux.
// Optional macro CNT_BANK_SYNC_RESTART_EN: any wrap clears every channel.
module cnt_bank #(
    parameter int N_CH     = 2,
    parameter int CNT_W    = 34,
    parameter int DISP_W   = 16,
    parameter int SCAN_DIV = 100000000,
    localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   en,
    input  logic [N_CH-1:0]   mode_sat,
    input  logic              clr,
    input  logic              snap,
    input  logic              scan_en,
    input  logic [SEL_W-1:0]  sel,
    output logic [DISP_W-1:0] rd_data,
    output logic [SEL_W-1:0]  rd_ch,
    output logic [N_CH-1:0]   tc,
    output logic              snap_valid
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [SEL_W:0]   NCH_L    = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] MAX_V    = '1;
    localparam logic [CNT_W-1:0] PRE_V    = {{(CNT_W - 1){1'b1}}, 1'b0};

    logic [CNT_W-1:0]  cnt     [N_CH];
    logic [CNT_W-1:0]  cnt_nxt [N_CH];
    logic [DISP_W-1:0] shadow  [N_CH];
    logic [N_CH-1:0]   wrap_hit;
    logic [N_CH-1:0]   sat_hit;
    logic [N_CH-1:0]   tc_nxt;
    logic              restart;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  div_nxt;
    logic              tick;
    logic [SEL_W-1:0]  sel_eff;
    logic [SEL_W-1:0]  ch_inc;
    logic [SEL_W-1:0]  idx_nxt;

    // Terminal-count conditions: wrap edge or reaching all-ones in saturate mode.
    always_comb begin
        wrap_hit = '0;
        sat_hit  = '0;
        for (int i = 0; i < N_CH; i++) begin
            wrap_hit[i] = ~clr & en[i] & ~mode_sat[i] & (cnt[i] == MAX_V);
            sat_hit[i]  = ~clr & en[i] & mode_sat[i] & (cnt[i] == PRE_V);
        end
    end

`ifdef CNT_BANK_SYNC_RESTART_EN
    assign restart = |wrap_hit;
    assign tc_nxt  = restart ? wrap_hit : (wrap_hit | sat_hit);
`else
    assign restart = 1'b0;
    assign tc_nxt  = wrap_hit | sat_hit;
`endif

    // Next counter value: clear/restart beat enable; saturating channels hold at max.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (clr || restart) begin
                cnt_nxt[i] = '0;
            end else if (en[i]) begin
                if (cnt[i] != MAX_V) begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end else if (!mode_sat[i]) begin
                    cnt_nxt[i] = '0;
                end
            end
        end
    end

    // Counter and terminal-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
            tc <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_nxt[i];
            tc <= tc_nxt;
        end
    end

    // Coherent snapshot of the visible window of every channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
            snap_valid <= 1'b0;
        end else if (snap) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= cnt[i][CNT_W-1 -: DISP_W];
            end
            snap_valid <= 1'b1;
        end
    end

    // Channel selection: manual with range fold, or divider-paced scan from rd_ch.
    always_comb begin
        tick    = (div == DIV_LAST);
        sel_eff = ({1'b0, sel} < NCH_L) ? sel : '0;
        ch_inc  = (rd_ch == LAST_CH) ? '0 : rd_ch + 1'b1;
        if (scan_en) begin
            idx_nxt = tick ? ch_inc : rd_ch;
            div_nxt = tick ? '0 : div + 1'b1;
        end else begin
            idx_nxt = sel_eff;
            div_nxt = '0;
        end
    end

    // Registered read port and scan divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div     <= '0;
            rd_ch   <= '0;
            rd_data <= '0;
        end else begin
            div     <= div_nxt;
            rd_ch   <= idx_nxt;
            rd_data <= shadow[idx_nxt];
        end
    end

endmodule

// File: tb/tb_cnt_bank.sv
// tb_cnt_bank: randomized scoreboard bench for cnt_bank.
// Reference model follows the counting/snapshot/scan rules arithmetically.
module tb_cnt_bank;

    localparam int N  = 3;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int SD = 3;
    localparam int MX = (1 << W) - 1;

    typedef struct {
        logic [D-1:0] d;
        logic [1:0]   ch;
        logic [N-1:0] tc;
        logic         sv;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] en = '0;
    logic [N-1:0] mode_sat = '0;
    logic         clr = 1'b0;
    logic         snap = 1'b0;
    logic         scan_en = 1'b0;
    logic [1:0]   sel = '0;
    logic [D-1:0] rd_data;
    logic [1:0]   rd_ch;
    logic [N-1:0] tc;
    logic         snap_valid;

    int errors = 0;
    int checks = 0;
    exp_t q[$];

    int unsigned m_cnt [N];
    int unsigned m_shd [N];
    bit          m_sv;
    int          m_div;
    int          m_ch;

    cnt_bank #(
        .N_CH(N), .CNT_W(W), .DISP_W(D), .SCAN_DIV(SD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode_sat(mode_sat),
        .clr(clr), .snap(snap), .scan_en(scan_en), .sel(sel),
        .rd_data(rd_data), .rd_ch(rd_ch), .tc(tc),
        .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_shd[i] = 0;
        end
        m_sv  = 0;
        m_div = 0;
        m_ch  = 0;
    endtask

    // One clock of stimulus; the expected post-edge outputs are queued.
    task automatic step(input logic r, input logic [N-1:0] e,
                        input logic [N-1:0] ms, input logic c,
                        input logic s, input logic sc,
                        input logic [1:0] sl);
        int unsigned nxt [N];
        logic [N-1:0] t;
        logic [N-1:0] wr;
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode_sat = ms; clr = c;
        snap = s; scan_en = sc; sel = sl;
        if (r) begin
            model_reset();
            x.d = '0; x.ch = '0; x.tc = '0; x.sv = 1'b0;
            q.push_back(x);
            return;
        end
        t = '0;
        wr = '0;
        for (int i = 0; i < N; i++) begin
            nxt[i] = m_cnt[i];
            if (c) begin
                nxt[i] = 0;
            end else if (e[i]) begin
                if (ms[i]) begin
                    if (m_cnt[i] < MX) begin
                        nxt[i] = m_cnt[i] + 1;
                        if (nxt[i] == MX) t[i] = 1'b1;
                    end
                end else begin
                    nxt[i] = (m_cnt[i] + 1) % (MX + 1);
                    if (nxt[i] == 0) begin
                        t[i] = 1'b1;
                        wr[i] = 1'b1;
                    end
                end
            end
        end
`ifdef CNT_BANK_SYNC_RESTART_EN
        if (wr != 0) begin
            for (int i = 0; i < N; i++) nxt[i] = 0;
            t = wr;
        end
`endif
        if (sc) begin
            if (m_div == SD - 1) begin
                m_div = 0;
                m_ch = (m_ch + 1) % N;
            end else begin
                m_div++;
            end
        end else begin
            m_div = 0;
            m_ch = (sl < N) ? int'(sl) : 0;
        end
        x.d  = D'(m_shd[m_ch] >> (W - D));
        x.ch = 2'(m_ch);
        x.tc = t;
        if (s) begin
            for (int i = 0; i < N; i++) m_shd[i] = m_cnt[i];
            m_sv = 1;
        end
        x.sv = m_sv;
        for (int i = 0; i < N; i++) m_cnt[i] = nxt[i];
        q.push_back(x);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rd_data !== '0 || rd_ch !== '0 || tc !== '0 || snap_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: rd_data=%0d rd_ch=%0d tc=%b sv=%b, want all 0",
                     rd_data, rd_ch, tc, snap_valid);
        end
        model_reset();
        step(1, 3'b111, mode_sat, 0, 0, scan_en, sel);
        step(1, 3'b111, mode_sat, 0, 0, scan_en, sel);
    endtask

    // Monitor: compare each registered output against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (rd_data !== e.d || rd_ch !== e.ch || tc !== e.tc || snap_valid !== e.sv) begin
                    errors++;
                    $display("FAIL out t=%0t: rd_data=%0d rd_ch=%0d tc=%b sv=%b, want %0d %0d %b %b",
                             $time, rd_data, rd_ch, tc, snap_valid, e.d, e.ch, e.tc, e.sv);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ms;
        logic         sc;
        model_reset();
        step(1, '0, '0, 0, 0, 0, 0);
        step(1, '0, '0, 0, 0, 0, 0);
        repeat (16) step(0, 3'b001, 3'b000, 0, 0, 0, 2'd0);
        repeat (20) step(0, 3'b010, 3'b010, 0, 0, 0, 2'd1);
        step(0, 3'b000, 3'b000, 1, 0, 0, 2'd1);
        repeat (5) step(0, 3'b011, 3'b000, 0, 0, 0, 2'd1);
        repeat (4) step(0, 3'b001, 3'b000, 0, 0, 0, 2'd1);
        step(0, 3'b000, 3'b000, 1, 1, 0, 2'd1);
        repeat (2) step(0, 3'b000, 3'b000, 0, 0, 0, 2'd1);
        repeat (6) step(0, 3'b111, 3'b000, 0, 0, 0, 2'd0);
        do_reset();
        repeat (3) step(0, 3'b111, 3'b000, 0, 1, 0, 2'd2);
        repeat (12) step(0, 3'b011, 3'b000, 0, 0, 1, 2'd0);
        repeat (2) step(0, 3'b011, 3'b000, 0, 0, 0, 2'd3);
        repeat (7) step(0, 3'b011, 3'b010, 0, 0, 0, 2'd1);
        repeat (3) step(0, 3'b011, 3'b010, 0, 1, 0, 2'd1);
        ms = '0;
        sc = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 7) == 0) ms = N'($urandom);
            if ($urandom_range(0, 31) == 0) sc = ~sc;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step(0, N'($urandom), ms,
                     ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 3) == 0),
                     sc, 2'($urandom));
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
